// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types and constants for the cache-pair AXI read arbiter.
// Holds the FSM state encoding, requester ids and AXI burst constants.
package axi_rd_arbiter_pkg;

  localparam int         CACHE_LINE_WORDS = 8;
  localparam logic [1:0] AXI_BURST_INCR   = 2'b01;
  localparam logic [2:0] AXI_SIZE_WORD    = 3'd2;
  localparam logic [3:0] RD_ID_IC         = 4'd0;
  localparam logic [3:0] RD_ID_DC         = 4'd1;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_AR   = 2'd1,
    RD_R    = 2'd2
  } rd_state_e;

  typedef enum logic {
    OWNER_IC = 1'b0,
    OWNER_DC = 1'b1
  } rd_owner_e;

endpackage

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read channel between icache refill and dcache reads.
// One transaction in flight at a time, dcache has fixed priority over icache.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int         LINE_WORDS = CACHE_LINE_WORDS,
  parameter logic [3:0] ID_IC      = RD_ID_IC,
  parameter logic [3:0] ID_DC      = RD_ID_DC
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ic_rd_req,
  input  logic [31:0]                   ic_rd_addr,
  output logic                          ic_rd_rdy,
  output logic                          ic_ret_valid,
  output logic                          ic_ret_last,
  output logic [$clog2(LINE_WORDS)-1:0] ic_ret_idx,
  output logic [31:0]                   ic_ret_data,
  input  logic                          dc_rd_req,
  input  logic                          dc_rd_single,
  input  logic [1:0]                    dc_rd_size,
  input  logic [31:0]                   dc_rd_addr,
  output logic                          dc_rd_rdy,
  output logic                          dc_ret_valid,
  output logic                          dc_ret_last,
  output logic [$clog2(LINE_WORDS)-1:0] dc_ret_idx,
  output logic [31:0]                   dc_ret_data,
  output logic [3:0]                    arid,
  output logic [31:0]                   araddr,
  output logic [7:0]                    arlen,
  output logic [2:0]                    arsize,
  output logic [1:0]                    arburst,
  output logic                          arvalid,
  input  logic                          arready,
  input  logic [3:0]                    rid,
  input  logic [31:0]                   rdata,
  input  logic                          rlast,
  input  logic                          rvalid,
  output logic                          rready
);

  localparam int         IDX_W    = $clog2(LINE_WORDS);
  localparam logic [7:0] LINE_LEN = 8'(LINE_WORDS - 1);

  rd_state_e        r_state;
  rd_state_e        w_next_state;
  rd_owner_e        r_owner;
  logic             w_grant_ic;
  logic             w_grant_dc;
  logic             w_beat_acc;
  logic [31:0]      r_araddr;
  logic [3:0]       r_arid;
  logic [7:0]       r_arlen;
  logic [2:0]       r_arsize;
  logic [IDX_W-1:0] r_beat_cnt;
  logic             w_unused_rid;

  always_ff @(posedge clk) begin
    if (reset) r_state <= RD_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_grant_ic   = 1'b0;
    w_grant_dc   = 1'b0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    case (r_state)
      RD_IDLE: begin
        if (dc_rd_req) begin
          w_grant_dc   = 1'b1;
          w_next_state = RD_AR;
        end else if (ic_rd_req) begin
          w_grant_ic   = 1'b1;
          w_next_state = RD_AR;
        end
      end
      RD_AR: begin
        arvalid = 1'b1;
        if (arready) w_next_state = RD_R;
      end
      RD_R: begin
        rready = 1'b1;
        // Burst end comes from rlast alone, never from the beat counter.
        if (rvalid && rlast) w_next_state = RD_IDLE;
      end
      default: w_next_state = RD_IDLE;
    endcase
  end

  // Payload is captured only on a grant, so it cannot move while arvalid is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner  <= OWNER_IC;
      r_araddr <= '0;
      r_arid   <= '0;
      r_arlen  <= '0;
      r_arsize <= '0;
    end else if (w_grant_dc) begin
      r_owner  <= OWNER_DC;
      r_araddr <= dc_rd_addr;
      r_arid   <= ID_DC;
      r_arlen  <= dc_rd_single ? 8'd0 : LINE_LEN;
      r_arsize <= dc_rd_single ? {1'b0, dc_rd_size} : AXI_SIZE_WORD;
    end else if (w_grant_ic) begin
      r_owner  <= OWNER_IC;
      r_araddr <= ic_rd_addr;
      r_arid   <= ID_IC;
      r_arlen  <= LINE_LEN;
      r_arsize <= AXI_SIZE_WORD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                r_beat_cnt <= '0;
    else if (w_beat_acc && rlast) r_beat_cnt <= '0;
    else if (w_beat_acc)      r_beat_cnt <= r_beat_cnt + 1'b1;
  end

  assign w_beat_acc   = rready & rvalid;
  assign w_unused_rid = ^rid;

  assign ic_rd_rdy = w_grant_ic & ~reset;
  assign dc_rd_rdy = w_grant_dc & ~reset;

  assign arid    = r_arid;
  assign araddr  = r_araddr;
  assign arlen   = r_arlen;
  assign arsize  = r_arsize;
  assign arburst = AXI_BURST_INCR;

  assign ic_ret_valid = w_beat_acc & (r_owner == OWNER_IC);
  assign dc_ret_valid = w_beat_acc & (r_owner == OWNER_DC);
  assign ic_ret_last  = ic_ret_valid & rlast;
  assign dc_ret_last  = dc_ret_valid & rlast;
  assign ic_ret_idx   = r_beat_cnt;
  assign dc_ret_idx   = r_beat_cnt;
  assign ic_ret_data  = rdata;
  assign dc_ret_data  = rdata;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomised scoreboard bench for axi_rd_arbiter with a random-latency AXI slave.
// Expected AR payloads and returned beats are queued at issue and checked by a monitor.
module tb_axi_rd_arbiter;
  import axi_rd_arbiter_pkg::*;

  localparam int LW = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ic_rd_req = 1'b0;
  logic [31:0] ic_rd_addr = '0;
  logic        ic_rd_rdy, ic_ret_valid, ic_ret_last;
  logic [2:0]  ic_ret_idx;
  logic [31:0] ic_ret_data;
  logic        dc_rd_req = 1'b0;
  logic        dc_rd_single = 1'b0;
  logic [1:0]  dc_rd_size = '0;
  logic [31:0] dc_rd_addr = '0;
  logic        dc_rd_rdy, dc_ret_valid, dc_ret_last;
  logic [2:0]  dc_ret_idx;
  logic [31:0] dc_ret_data;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [3:0]  rid = '0;
  logic [31:0] rdata = '0;
  logic        rlast = 1'b0;
  logic        rvalid = 1'b0;
  logic        rready;

  axi_rd_arbiter dut (
    .clk(clk), .reset(reset),
    .ic_rd_req(ic_rd_req), .ic_rd_addr(ic_rd_addr), .ic_rd_rdy(ic_rd_rdy),
    .ic_ret_valid(ic_ret_valid), .ic_ret_last(ic_ret_last), .ic_ret_idx(ic_ret_idx),
    .ic_ret_data(ic_ret_data),
    .dc_rd_req(dc_rd_req), .dc_rd_single(dc_rd_single), .dc_rd_size(dc_rd_size),
    .dc_rd_addr(dc_rd_addr), .dc_rd_rdy(dc_rd_rdy),
    .dc_ret_valid(dc_ret_valid), .dc_ret_last(dc_ret_last), .dc_ret_idx(dc_ret_idx),
    .dc_ret_data(dc_ret_data),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } ar_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  ar_t   arQ[$];
  beat_t beatQ[$];

  int checks = 0;
  int errors = 0;

  // Transaction-level view: whether the channel is taken, and which phase it is in.
  bit busy = 0;
  bit arPending = 0;
  bit dataPhase = 0;
  bit ownerDc = 0;
  int beatCnt = 0;

  // Slave and requester bookkeeping, sampled on the falling edge.
  bit icRdySeen, dcRdySeen, arHs, rHs;
  int curLen;
  int beatsLeft = 0;
  bit slaveActive = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: sample on the falling edge, then drive requesters and slave after the rising edge.
  task automatic applyStimulus(input bit allowNew, input bit rst);
    @(negedge clk);
    icRdySeen = ic_rd_rdy;
    dcRdySeen = dc_rd_rdy;
    arHs      = arvalid && arready;
    rHs       = rvalid && rready;
    curLen    = int'(arlen);
    @(posedge clk);
    #1;
    reset = rst;
    if (rst) begin
      ic_rd_req   = 1'b0;
      dc_rd_req   = 1'b0;
      arready     = 1'b0;
      rvalid      = 1'b0;
      rlast       = 1'b0;
      slaveActive = 0;
      beatsLeft   = 0;
      return;
    end
    if (icRdySeen) ic_rd_req = 1'b0;
    else if (!ic_rd_req && allowNew && $urandom_range(0, 3) == 0) begin
      ic_rd_req  = 1'b1;
      ic_rd_addr = $urandom & 32'hffff_ffe0;
    end
    if (dcRdySeen) dc_rd_req = 1'b0;
    else if (!dc_rd_req && allowNew && $urandom_range(0, 4) == 0) begin
      dc_rd_req    = 1'b1;
      dc_rd_single = 1'($urandom_range(0, 1));
      dc_rd_size   = 2'($urandom_range(0, 2));
      dc_rd_addr   = $urandom;
    end
    if (rHs) begin
      beatsLeft--;
      if (beatsLeft <= 0) slaveActive = 0;
    end
    if (arHs) begin
      slaveActive = 1;
      beatsLeft   = curLen + 1;
    end
    arready = ($urandom_range(0, 2) != 0);
    if (!(rvalid && !rHs)) begin
      if (slaveActive && beatsLeft > 0 && $urandom_range(0, 3) != 0) begin
        rvalid = 1'b1;
        rdata  = $urandom;
        rid    = 4'($urandom);
        rlast  = (beatsLeft == 1);
        beatQ.push_back('{data: rdata, last: rlast});
      end else begin
        rvalid = 1'b0;
        rlast  = 1'b0;
      end
    end
  endtask

  task automatic waitIdle(input string name, input int budget);
    int n;
    n = 0;
    while ((busy || ic_rd_req || dc_rd_req) && n < budget) begin
      applyStimulus(0, 0);
      n++;
    end
    if (busy || ic_rd_req || dc_rd_req) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: still busy after %0d cycles, expected idle", name, budget);
    end
  endtask

  // Scoreboard monitor: checks the DUT against the transaction model every cycle.
  initial begin
    bit    expIc, expDc;
    beat_t b;
    forever begin
      @(negedge clk);
      if (reset) begin
        checkOutput("rdy_in_reset", {62'd0, ic_rd_rdy, dc_rd_rdy}, 64'd0);
        busy = 0; arPending = 0; dataPhase = 0; beatCnt = 0;
        arQ.delete();
        beatQ.delete();
      end else begin
        expIc = 0;
        expDc = 0;
        if (!busy) begin
          if (dc_rd_req)      expDc = 1;
          else if (ic_rd_req) expIc = 1;
        end
        checkOutput("dc_rd_rdy", dc_rd_rdy, expDc);
        checkOutput("ic_rd_rdy", ic_rd_rdy, expIc);
        checkOutput("arvalid", arvalid, arPending);
        checkOutput("rready", rready, dataPhase);
        if (arPending) begin
          checkOutput("arid", arid, arQ[0].id);
          checkOutput("araddr", araddr, arQ[0].addr);
          checkOutput("arlen", arlen, arQ[0].len);
          checkOutput("arsize", arsize, arQ[0].size);
          checkOutput("arburst", arburst, 2'b01);
        end
        checkOutput("ic_ret_valid", ic_ret_valid, dataPhase && rvalid && !ownerDc);
        checkOutput("dc_ret_valid", dc_ret_valid, dataPhase && rvalid && ownerDc);
        if (ic_ret_valid || dc_ret_valid) begin
          if (beatQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL ret_unexpected: beat presented, expected none at %0t", $time);
          end else begin
            b = beatQ.pop_front();
            if (ic_ret_valid) begin
              checkOutput("ic_ret_data", ic_ret_data, b.data);
              checkOutput("ic_ret_last", ic_ret_last, b.last);
              checkOutput("ic_ret_idx", ic_ret_idx, 64'(beatCnt % LW));
            end else begin
              checkOutput("dc_ret_data", dc_ret_data, b.data);
              checkOutput("dc_ret_last", dc_ret_last, b.last);
              checkOutput("dc_ret_idx", dc_ret_idx, 64'(beatCnt % LW));
            end
          end
        end
        if (dataPhase && rvalid) begin
          beatCnt++;
          if (rlast) begin
            dataPhase = 0;
            busy      = 0;
          end
        end
        if (arPending && arready) begin
          void'(arQ.pop_front());
          arPending = 0;
          dataPhase = 1;
          beatCnt   = 0;
        end
        if (expDc) begin
          busy = 1; arPending = 1; ownerDc = 1;
          arQ.push_back('{id: 4'd1, addr: dc_rd_addr, len: dc_rd_single ? 8'd0 : 8'(LW - 1),
                         size: dc_rd_single ? {1'b0, dc_rd_size} : 3'd2});
        end else if (expIc) begin
          busy = 1; arPending = 1; ownerDc = 0;
          arQ.push_back('{id: 4'd0, addr: ic_rd_addr, len: 8'(LW - 1), size: 3'd2});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    applyStimulus(0, 1);
    applyStimulus(0, 1);
    applyStimulus(0, 0);

    // Simultaneous requests: uncached dcache byte read beats the icache line refill.
    ic_rd_req    = 1'b1;
    ic_rd_addr   = 32'h1fc0_0020;
    dc_rd_req    = 1'b1;
    dc_rd_single = 1'b1;
    dc_rd_size   = 2'd0;
    dc_rd_addr   = 32'hbfaf_f003;
    waitIdle("directed_pair", 400);

    for (int i = 0; i < 3000; i++) applyStimulus(1, 0);
    waitIdle("random_drain", 600);

    // Reset in the middle of an icache burst, then a fresh refill.
    ic_rd_req  = 1'b1;
    ic_rd_addr = 32'h0040_1000;
    n = 0;
    while (!(dataPhase && beatCnt >= 4) && n < 300) begin
      applyStimulus(0, 0);
      n++;
    end
    if (!(dataPhase && beatCnt >= 4)) begin
      checks++;
      errors++;
      $display("[TB] FAIL reset_setup: burst never reached beat 4, expected it within 300 cycles");
    end
    applyStimulus(0, 1);
    applyStimulus(0, 0);
    ic_rd_req  = 1'b1;
    ic_rd_addr = 32'h0040_2000;
    waitIdle("post_reset", 400);
    applyStimulus(0, 0);

    checkOutput("arQ_empty", arQ.size(), 64'd0);
    checkOutput("beatQ_empty", beatQ.size(), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
